// File: rtl/engine_read_write_responder_pkg.sv
// Shared types for the engine read/write responder: request address/data
// containers, the response record, the command encoding and FSM states.
package engine_read_write_responder_pkg;

  localparam int RW_DATA_W  = 32;
  localparam int RW_TAG_W   = 8;
  localparam int PKT_ADDR_W = 32;
  localparam int PKT_ID_W   = 8;
  localparam int PKT_FIELDS = 4;

  typedef enum logic {
    RW_READ  = 1'b0,
    RW_WRITE = 1'b1
  } ReadWriteCmd;

  typedef enum logic [1:0] {
    RESP_RUN   = 2'd0,
    RESP_DRAIN = 2'd1,
    RESP_DONE  = 2'd2
  } ResponderState;

  // Byte offset plus buffer id; the shift fields belong to other engines
  // and are carried through untouched by this responder.
  typedef struct packed {
    logic [PKT_ID_W-1:0]   id_buffer;
    logic [PKT_ADDR_W-1:0] offset;
    logic [7:0]            shift_start;
    logic [7:0]            shift_end;
  } PacketDataAddress;

  typedef struct packed {
    logic [PKT_FIELDS-1:0][RW_DATA_W-1:0] field;
  } EnginePacketData;

  typedef struct packed {
    logic [RW_TAG_W-1:0]  tag;
    ReadWriteCmd          cmd;
    logic                 error;
    logic [RW_DATA_W-1:0] data;
  } ReadWriteResponse;

  // Number of low offset bits that select a byte within one scratchpad word.
  function automatic int unsigned byte_shift(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/engine_read_write_responder_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count and a
// synchronous flush that empties it in one cycle.
module engine_read_write_responder_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 8
) (
  input  logic                     ap_clk,
  input  logic                     areset_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             push;
  logic             pop;

  // The owner never writes while full, so push needs no full guard.
  assign push    = wr_en & ~flush;
  assign pop     = rd_en & ~empty & ~flush;
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = store[rd_ptr];

  // Pointer and occupancy bookkeeping; flush discards every stored entry.
  always_ff @(posedge ap_clk) begin
    if (!areset_n || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; data words are never reset.
  always_ff @(posedge ap_clk) begin
    if (push) store[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/engine_read_write_responder.sv
// Target end of the engine read/write path: decodes requests, serves them
// from a local scratchpad through a 2-stage pipe and returns in-order
// responses with credit-based backpressure and a clear/drain handshake.
module engine_read_write_responder
  import engine_read_write_responder_pkg::*;
#(
  parameter int DATA_W          = RW_DATA_W,
  parameter int DEPTH           = 1024,
  parameter int BUFFER_ID       = 0,
  parameter int TAG_W           = RW_TAG_W,
  parameter int RESP_FIFO_DEPTH = 8,
  parameter int WRITE_ACK       = 1
) (
  input  logic              ap_clk,
  input  logic              areset_n,
  input  logic              clear_in,
  input  logic              req_valid_in,
  output logic              req_ready_out,
  input  logic              req_cmd_in,
  input  PacketDataAddress  req_address_in,
  input  EnginePacketData   req_data_in,
  input  logic [TAG_W-1:0]  req_tag_in,
  output logic              resp_valid_out,
  input  logic              resp_ready_in,
  output ReadWriteResponse  resp_out,
  output logic              busy_out,
  output logic              done_out
);

  localparam int IDX_W      = $clog2(DEPTH);
  localparam int BYTE_SHIFT = byte_shift(DATA_W);
  localparam int CRED_W     = $clog2(RESP_FIFO_DEPTH + 1);
  localparam int CNT_W      = $clog2(RESP_FIFO_DEPTH) + 1;

  ResponderState state_q, state_d;
  logic run, drain;

  logic [PKT_ADDR_W-1:0] word_addr;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_err;
  logic                  resp_gen;
  logic                  accept;
  ReadWriteCmd           req_cmd;
  logic [DATA_W-1:0]     req_wdata;
  logic                  unused_req_bits;

  logic [CRED_W-1:0] credits;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              vld_p0;
  logic [TAG_W-1:0]  tag_p0;
  ReadWriteCmd       cmd_p0;
  logic              err_p0;
  logic [IDX_W-1:0]  idx_p0;
  logic [DATA_W-1:0] wdata_p0;

  logic              vld_p1;
  logic [TAG_W-1:0]  tag_p1;
  ReadWriteCmd       cmd_p1;
  logic              err_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic [DATA_W-1:0] rdata_p1;

  ReadWriteResponse  fifo_din;
  ReadWriteResponse  fifo_dout;
  logic              fifo_wr;
  logic              fifo_rd;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  // Request decode: byte offset to word index, range and buffer-id check.
  assign req_cmd   = ReadWriteCmd'(req_cmd_in);
  assign word_addr = req_address_in.offset >> BYTE_SHIFT;
  assign dec_idx   = word_addr[IDX_W-1:0];
  assign dec_err   = (word_addr >= PKT_ADDR_W'(DEPTH)) ||
                     (req_address_in.id_buffer != PKT_ID_W'(BUFFER_ID));
  assign req_wdata = req_data_in.field[0][DATA_W-1:0];
  // Error writes always answer so the requester learns of the fault.
  assign resp_gen  = (req_cmd == RW_READ) || dec_err || (WRITE_ACK != 0);
  assign accept    = req_valid_in & req_ready_out;

  assign unused_req_bits = ^{req_address_in.shift_start, req_address_in.shift_end,
                             req_data_in.field[PKT_FIELDS-1:1]};

  // FSM state register.
  always_ff @(posedge ap_clk) begin
    if (!areset_n) state_q <= RESP_RUN;
    else           state_q <= state_d;
  end

  // FSM next state and mode decodes; ready also sees clear_in so no request
  // slips in on the cycle a flush is requested.
  always_comb begin
    state_d       = state_q;
    run           = 1'b0;
    drain         = 1'b0;
    done_out      = 1'b0;
    case (state_q)
      RESP_RUN: begin
        run = 1'b1;
        if (clear_in) state_d = RESP_DRAIN;
      end
      RESP_DRAIN: begin
        drain = 1'b1;
        if (!vld_p0 && !vld_p1) state_d = RESP_DONE;
      end
      RESP_DONE: begin
        done_out = 1'b1;
        state_d  = clear_in ? RESP_DRAIN : RESP_RUN;
      end
      default: state_d = RESP_RUN;
    endcase
    req_ready_out = areset_n && run && !clear_in && (credits != '0);
  end

  // Credits track free FIFO slots minus responses already in the pipe.
  always_ff @(posedge ap_clk) begin
    if (!areset_n || done_out) begin
      credits <= CRED_W'(RESP_FIFO_DEPTH);
    end else begin
      case ({accept & resp_gen, fifo_rd})
        2'b10:   credits <= credits - CRED_W'(1);
        2'b01:   credits <= credits + CRED_W'(1);
        default: credits <= credits;
      endcase
    end
  end

  // Scratchpad write port: writes commit on the accepting edge.
  always_ff @(posedge ap_clk) begin
    if (accept && (req_cmd == RW_WRITE) && !dec_err) mem[dec_idx] <= req_wdata;
  end

  // Stage p0 control: request captured on the accepting edge.
  always_ff @(posedge ap_clk) begin
    if (!areset_n) vld_p0 <= 1'b0;
    else           vld_p0 <= accept & resp_gen;
  end

  // Stage p0 data.
  always_ff @(posedge ap_clk) begin
    tag_p0   <= req_tag_in;
    cmd_p0   <= req_cmd;
    err_p0   <= dec_err;
    idx_p0   <= dec_idx;
    wdata_p0 <= req_wdata;
  end

  // Stage p1 control.
  always_ff @(posedge ap_clk) begin
    if (!areset_n) vld_p1 <= 1'b0;
    else           vld_p1 <= vld_p0;
  end

  // Stage p1 data: memory output register; a write one cycle earlier is
  // already in the array, so read-after-write sees the new word.
  always_ff @(posedge ap_clk) begin
    tag_p1   <= tag_p0;
    cmd_p1   <= cmd_p0;
    err_p1   <= err_p0;
    wdata_p1 <= wdata_p0;
    rdata_p1 <= mem[idx_p0];
  end

  // Response assembly ahead of the FIFO.
  always_comb begin
    fifo_din       = '0;
    fifo_din.tag   = tag_p1;
    fifo_din.cmd   = cmd_p1;
    fifo_din.error = err_p1;
    if (!err_p1) fifo_din.data = (cmd_p1 == RW_WRITE) ? wdata_p1 : rdata_p1;
  end

  // Responses from the pipe are dropped while draining.
  assign fifo_wr = vld_p1 & run;
  assign fifo_rd = resp_valid_out & resp_ready_in;

  engine_read_write_responder_fifo #(
    .WIDTH ($bits(ReadWriteResponse)),
    .DEPTH (RESP_FIFO_DEPTH)
  ) u_resp_fifo (
    .ap_clk   (ap_clk),
    .areset_n (areset_n),
    .flush    (drain),
    .wr_en    (fifo_wr),
    .wr_data  (fifo_din),
    .rd_en    (fifo_rd),
    .rd_data  (fifo_dout),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign resp_valid_out = run & ~fifo_empty;
  assign resp_out       = resp_valid_out ? fifo_dout : '0;
  assign busy_out       = vld_p0 | vld_p1 | (fifo_count != '0);

endmodule

// File: tb/tb_engine_read_write_responder.sv
// Directed bench for engine_read_write_responder: a vector table for single
// transactions with exact latency, plus hand sequences for ordering,
// backpressure, clear/drain and mid-stream reset.
module tb_engine_read_write_responder;
  import engine_read_write_responder_pkg::*;

  logic             ap_clk = 1'b0;
  logic             areset_n;
  logic             clear_in;
  logic             req_valid_in;
  logic             req_ready_out;
  logic             req_cmd_in;
  PacketDataAddress req_address_in;
  EnginePacketData  req_data_in;
  logic [7:0]       req_tag_in;
  logic             resp_valid_out;
  logic             resp_ready_in;
  ReadWriteResponse resp_out;
  logic             busy_out;
  logic             done_out;

  always #5 ap_clk = ~ap_clk;

  engine_read_write_responder dut (
    .ap_clk         (ap_clk),
    .areset_n       (areset_n),
    .clear_in       (clear_in),
    .req_valid_in   (req_valid_in),
    .req_ready_out  (req_ready_out),
    .req_cmd_in     (req_cmd_in),
    .req_address_in (req_address_in),
    .req_data_in    (req_data_in),
    .req_tag_in     (req_tag_in),
    .resp_valid_out (resp_valid_out),
    .resp_ready_in  (resp_ready_in),
    .resp_out       (resp_out),
    .busy_out       (busy_out),
    .done_out       (done_out)
  );

  typedef struct {
    logic        cmd;
    logic [7:0]  id;
    logic [31:0] off;
    logic [7:0]  shf;
    logic [31:0] wdata;
    logic [7:0]  tag;
    logic        eerr;
    logic [31:0] edata;
  } vec_t;

  vec_t             vecs [10];
  int               checks = 0;
  int               errors = 0;
  ReadWriteResponse rq [$];

  // Capture every response handshake.
  always @(negedge ap_clk) begin
    if (areset_n && resp_valid_out && resp_ready_in) rq.push_back(resp_out);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic ReadWriteResponse mk(input logic [7:0] tag, input logic cmd,
                                          input logic err, input logic [31:0] data);
    ReadWriteResponse r;
    r.tag   = tag;
    r.cmd   = ReadWriteCmd'(cmd);
    r.error = err;
    r.data  = data;
    return r;
  endfunction

  task automatic drive_req(input logic cmd, input logic [7:0] id, input logic [31:0] off,
                           input logic [7:0] shf, input logic [31:0] wdata, input logic [7:0] tag);
    req_cmd_in                 = cmd;
    req_address_in.id_buffer   = id;
    req_address_in.offset      = off;
    req_address_in.shift_start = shf;
    req_address_in.shift_end   = shf;
    req_data_in.field[0]       = wdata;
    req_data_in.field[1]       = ~wdata;
    req_data_in.field[2]       = 32'h0BAD0BAD;
    req_data_in.field[3]       = 32'hFFFFFFFF;
    req_tag_in                 = tag;
    req_valid_in               = 1'b1;
  endtask

  // Offer requests (tag = running accept count) until max_acc accepted or
  // the cycle budget runs out; returns #1 after an edge with valid still high.
  task automatic stream(input int max_acc, input int cycles, inout int acc);
    logic hit;
    for (int c = 0; c < cycles && acc < max_acc; c++) begin
      req_tag_in = 8'(acc);
      @(negedge ap_clk);
      hit = req_ready_out;
      @(posedge ap_clk);
      #1;
      if (hit) acc++;
    end
  endtask

  task automatic wait_q(input int n, input string name);
    int c;
    c = 0;
    while (rq.size() < n && c < 200) begin
      @(posedge ap_clk);
      c++;
    end
    chk(name, 64'(rq.size() >= n), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    int vcnt;
    int dcnt;
    ReadWriteResponse held;

    vecs[0] = '{1'b1, 8'd0, 32'h10,   8'h00, 32'hDEADBEEF, 8'd3,  1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 8'd0, 32'h10,   8'h00, 32'h0,        8'd4,  1'b0, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 8'd0, 32'h14,   8'h00, 32'h1111,     8'd5,  1'b0, 32'h1111};
    vecs[3] = '{1'b0, 8'd0, 32'h1000, 8'h00, 32'h0,        8'd6,  1'b1, 32'h0};
    vecs[4] = '{1'b1, 8'd0, 32'h20,   8'h00, 32'h5555,     8'd7,  1'b0, 32'h5555};
    vecs[5] = '{1'b1, 8'd1, 32'h20,   8'h00, 32'hCAFE,     8'd8,  1'b1, 32'h0};
    vecs[6] = '{1'b0, 8'd0, 32'h20,   8'h00, 32'h0,        8'd9,  1'b0, 32'h5555};
    vecs[7] = '{1'b1, 8'd0, 32'hFFC,  8'h00, 32'hA5A5A5A5, 8'd10, 1'b0, 32'hA5A5A5A5};
    vecs[8] = '{1'b0, 8'd0, 32'hFFC,  8'h00, 32'h0,        8'd11, 1'b0, 32'hA5A5A5A5};
    vecs[9] = '{1'b0, 8'd0, 32'h13,   8'hFF, 32'h0,        8'd12, 1'b0, 32'hDEADBEEF};

    areset_n       = 1'b0;
    clear_in       = 1'b0;
    req_valid_in   = 1'b0;
    req_cmd_in     = 1'b0;
    req_address_in = '0;
    req_data_in    = '0;
    req_tag_in     = '0;
    resp_ready_in  = 1'b1;

    // Reset state
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_ready", 64'(req_ready_out), 64'd0);
    chk("rst_valid", 64'(resp_valid_out), 64'd0);
    chk("rst_resp", 64'(resp_out), 64'd0);
    chk("rst_busy", 64'(busy_out), 64'd0);
    chk("rst_done", 64'(done_out), 64'd0);
    @(posedge ap_clk);
    #1 areset_n = 1'b1;
    @(negedge ap_clk);
    chk("post_rst_ready", 64'(req_ready_out), 64'd1);

    // Table: one request each, exact latency and response contents
    for (int i = 0; i < 10; i++) begin
      @(posedge ap_clk);
      #1;
      drive_req(vecs[i].cmd, vecs[i].id, vecs[i].off, vecs[i].shf, vecs[i].wdata, vecs[i].tag);
      @(negedge ap_clk);
      chk($sformatf("v%0d_ready", i), 64'(req_ready_out), 64'd1);
      @(posedge ap_clk);
      #1 req_valid_in = 1'b0;
      @(negedge ap_clk);
      chk($sformatf("v%0d_busy", i), 64'(busy_out), 64'd1);
      @(negedge ap_clk);
      chk($sformatf("v%0d_early", i), 64'(resp_valid_out), 64'd0);
      @(negedge ap_clk);
      chk($sformatf("v%0d_valid", i), 64'(resp_valid_out), 64'd1);
      chk($sformatf("v%0d_resp", i), 64'(resp_out),
          64'(mk(vecs[i].tag, vecs[i].cmd, vecs[i].eerr, vecs[i].edata)));
    end

    // Write then read of the same word on consecutive cycles
    @(posedge ap_clk);
    #1;
    rq.delete();
    drive_req(1'b1, 8'd0, 32'h14, 8'h00, 32'h1234, 8'h13);
    @(posedge ap_clk);
    #1 drive_req(1'b0, 8'd0, 32'h14, 8'h00, 32'h0, 8'h14);
    @(posedge ap_clk);
    #1 req_valid_in = 1'b0;
    wait_q(2, "raw_count");
    if (rq.size() >= 2) begin
      chk("raw_ack", 64'(rq[0]), 64'(mk(8'h13, 1'b1, 1'b0, 32'h1234)));
      chk("raw_read", 64'(rq[1]), 64'(mk(8'h14, 1'b0, 1'b0, 32'h1234)));
    end

    // Credit limit with a stalled consumer, then in-order release
    repeat (3) @(posedge ap_clk);
    #1;
    rq.delete();
    resp_ready_in = 1'b0;
    drive_req(1'b0, 8'd0, 32'h10, 8'h00, 32'h0, 8'h00);
    acc = 0;
    stream(16, 20, acc);
    chk("bp_accepted", 64'(acc), 64'd8);
    @(negedge ap_clk);
    chk("bp_ready_low", 64'(req_ready_out), 64'd0);
    held = resp_out;
    chk("bp_head", 64'(held), 64'(mk(8'h00, 1'b0, 1'b0, 32'hDEADBEEF)));
    repeat (2) @(negedge ap_clk);
    chk("bp_stable", 64'(resp_out), 64'(held));
    @(posedge ap_clk);
    #1 resp_ready_in = 1'b1;
    stream(16, 200, acc);
    req_valid_in = 1'b0;
    chk("bp_all_accepted", 64'(acc), 64'd16);
    wait_q(16, "bp_count_reached");
    repeat (5) @(posedge ap_clk);
    chk("bp_no_dup", 64'(rq.size()), 64'd16);
    for (int i = 0; i < 16 && i < rq.size(); i++)
      chk($sformatf("bp_order%0d", i), 64'(rq[i]), 64'(mk(8'(i), 1'b0, 1'b0, 32'hDEADBEEF)));

    // Clear with requests in the pipe and the FIFO
    @(posedge ap_clk);
    #1;
    rq.delete();
    resp_ready_in = 1'b0;
    drive_req(1'b0, 8'd0, 32'h10, 8'h00, 32'h0, 8'h00);
    acc = 0;
    stream(7, 20, acc);
    req_valid_in = 1'b0;
    clear_in     = 1'b1;
    @(posedge ap_clk);
    #1 clear_in = 1'b0;
    vcnt = 0;
    dcnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge ap_clk);
      if (resp_valid_out) vcnt++;
      if (done_out) dcnt++;
    end
    chk("clr_accepted", 64'(acc), 64'd7);
    chk("clr_no_valid", 64'(vcnt), 64'd0);
    chk("clr_done_once", 64'(dcnt), 64'd1);
    chk("clr_idle", 64'(busy_out), 64'd0);
    @(posedge ap_clk);
    #1;
    resp_ready_in = 1'b1;
    drive_req(1'b0, 8'd0, 32'h10, 8'h00, 32'h0, 8'h30);
    @(posedge ap_clk);
    #1 req_valid_in = 1'b0;
    wait_q(1, "clr_next_count");
    repeat (5) @(posedge ap_clk);
    chk("clr_only_one", 64'(rq.size()), 64'd1);
    if (rq.size() >= 1) chk("clr_next_resp", 64'(rq[0]), 64'(mk(8'h30, 1'b0, 1'b0, 32'hDEADBEEF)));

    // Credits restored to the full FIFO depth
    #1;
    rq.delete();
    resp_ready_in = 1'b0;
    drive_req(1'b0, 8'd0, 32'h10, 8'h00, 32'h0, 8'h00);
    acc = 0;
    stream(12, 14, acc);
    chk("cred_full", 64'(acc), 64'd8);
    @(negedge ap_clk);
    chk("full_valid", 64'(resp_valid_out), 64'd1);

    // Reset mid-stream with the FIFO full
    @(posedge ap_clk);
    #1 areset_n = 1'b0;
    @(posedge ap_clk);
    @(negedge ap_clk);
    chk("mrst_ready", 64'(req_ready_out), 64'd0);
    chk("mrst_valid", 64'(resp_valid_out), 64'd0);
    chk("mrst_resp", 64'(resp_out), 64'd0);
    chk("mrst_busy", 64'(busy_out), 64'd0);
    chk("mrst_done", 64'(done_out), 64'd0);
    @(posedge ap_clk);
    #1;
    areset_n      = 1'b1;
    resp_ready_in = 1'b1;
    rq.delete();
    drive_req(1'b0, 8'd0, 32'h20, 8'h00, 32'h0, 8'h40);
    @(negedge ap_clk);
    chk("mrst_ready_after", 64'(req_ready_out), 64'd1);
    @(posedge ap_clk);
    #1 req_valid_in = 1'b0;
    wait_q(1, "mrst_next_count");
    repeat (5) @(posedge ap_clk);
    chk("mrst_only_one", 64'(rq.size()), 64'd1);
    if (rq.size() >= 1) chk("mrst_next_resp", 64'(rq[0]), 64'(mk(8'h40, 1'b0, 1'b0, 32'h5555)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
